// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared FSM state type and counter sizing for word_serializer.
// Package serializer_pkg (no ports):
//   state_t  IDLE / SHIFT / PARITY serializer states (PARITY is used only with SERIALIZER_PARITY_EN)
//   STATE_W  width of the state encoding
//   cnt_w()  width of the bit counter for a given word width (never below 1)
package serializer_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE, SHIFT, PARITY} state_t;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: parallel-word input and serial-bit output handshakes of word_serializer.
// Signals (W = word width, must match the W of the attached word_serializer):
//   word_in [W]  parallel word, sampled on accept      word_valid  upstream has a word
//   word_ready   serializer can take a word            bit_out     current serial bit
//   bit_valid    bit_out is meaningful                 bit_ready   downstream consumes bit_out
//   last_bit     bit_out is the final bit of a frame   busy        serializer is not idle
// Modports: master (feeds words, consumes bits), slave (the serializer).
interface word_serializer_if #(parameter int W = 16);
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         bit_ready;
    logic         last_bit;
    logic         busy;
    modport master (output word_in, word_valid, bit_ready,
                    input  word_ready, bit_out, bit_valid, last_bit, busy);
    modport slave  (input  word_in, word_valid, bit_ready,
                    output word_ready, bit_out, bit_valid, last_bit, busy);
endinterface

// File: rtl/word_serializer_parity.sv
// word_parity: parity of a W-bit word, even sense (0) or odd sense (1) chosen by PARITY_ODD.
// Ports:
//   word    in  W  word to reduce
//   parity  out 1  ^word ^ PARITY_ODD
module word_parity #(
    parameter int W          = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [W-1:0] word,
    output logic         parity
);
    assign parity = ^word ^ PARITY_ODD;
endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel word to LSB-first serial bit stream with valid/ready on both sides.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    word_serializer_if.slave: word_in/word_valid/word_ready in, bit_out/bit_valid/
//          bit_ready/last_bit out, busy
// Build option: define SERIALIZER_PARITY_EN to append a parity bit (sense PARITY_ODD) to
// every frame; otherwise frames are W data bits and PARITY_ODD is ignored.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int W          = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic               clock,
    input logic               reset,
    word_serializer_if.slave  bus
);
    localparam int            CW   = cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, state_n;
    logic [W-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          last;
    logic          adv, fin, accept, at_end;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PE = 1'b1;
    logic par_d, par_q;
    word_parity #(.W(W), .PARITY_ODD(PARITY_ODD)) u_parity (.word(bus.word_in), .parity(par_d));
    // The word is shifted away, so its parity is captured when it is accepted.
    always_ff @(posedge clock or posedge reset)
        if (reset) par_q <= 1'b0;
        else if (accept) par_q <= par_d;
`else
    localparam bit PE = 1'b0;
    logic par_q;
    logic unused_parity_odd;
    assign par_q             = 1'b0;
    assign unused_parity_odd = PARITY_ODD;
`endif

    assign adv    = bus.bit_valid && bus.bit_ready;
    assign fin    = adv && last;
    assign at_end = (state == SHIFT) && (cnt == LAST);
    // Ready combinationally follows bit_ready on the final bit so frames stream gap-free.
    assign bus.word_ready = (state == IDLE) || fin;
    assign accept         = bus.word_valid && bus.word_ready;

    // The shift register LSB is the registered serial output.
    assign bus.bit_out   = sh[0];
    assign bus.bit_valid = state != IDLE;
    assign bus.last_bit  = last;
    assign bus.busy      = state != IDLE;

    always_comb begin
        state_n = state;
        if (bus.word_ready)
            state_n = bus.word_valid ? SHIFT : IDLE;
        else if (adv && at_end)
            state_n = PARITY;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                sh   <= bus.word_in;
                cnt  <= '0;
                last <= !PE && (W == 1);
            end else if (adv && (state == SHIFT) && !at_end) begin
                sh   <= sh >> 1;
                cnt  <= cnt + 1'b1;
                last <= !PE && ((cnt + 1'b1) == LAST);
            end else if (adv && at_end && PE) begin
                sh   <= W'(par_q);
                cnt  <= '0;
                last <= 1'b1;
            end else if (adv) begin
                sh   <= '0;
                cnt  <= '0;
                last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed bench for word_serializer (W=16 and W=1) with a frame-queue model.
module tb_word_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif
    localparam bit PODD = 1'b0;
    localparam int FL   = 16 + PE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   acc16 = 0;
    int   acc1 = 0;
    logic [1:0] q16[$];
    logic [1:0] q1[$];
    logic rdy16, rdy1;

    always #5 clk = ~clk;

    word_serializer_if #(.W(16)) b16 ();
    word_serializer_if #(.W(1))  b1 ();

    word_serializer #(.W(16), .PARITY_ODD(PODD)) dut16 (.clock(clk), .reset(rst), .bus(b16));
    word_serializer #(.W(1),  .PARITY_ODD(PODD)) dut1  (.clock(clk), .reset(rst), .bus(b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a queue of {bit,last} entries; the head is on the wire.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q16.delete();
            q1.delete();
        end else begin
            rdy16 = (q16.size() == 0) || (q16.size() == 1 && b16.bit_ready);
            rdy1  = (q1.size() == 0) || (q1.size() == 1 && b1.bit_ready);
            if (q16.size() != 0 && b16.bit_ready) void'(q16.pop_front());
            if (q1.size() != 0 && b1.bit_ready) void'(q1.pop_front());
            if (b16.word_valid && rdy16) begin
                for (int i = 0; i < 16; i++) q16.push_back({b16.word_in[i], PE == 0 && i == 15});
                if (PE != 0) q16.push_back({^b16.word_in ^ PODD, 1'b1});
                acc16++;
            end
            if (b1.word_valid && rdy1) begin
                q1.push_back({b1.word_in[0], PE == 0});
                if (PE != 0) q1.push_back({b1.word_in[0] ^ PODD, 1'b1});
                acc1++;
            end
        end
    end

    // Compare just before each rising edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        #4;
        chk("valid16", b16.bit_valid, q16.size() != 0);
        chk("busy16", b16.busy, q16.size() != 0);
        chk("ready16", b16.word_ready, q16.size() == 0 || (q16.size() == 1 && b16.bit_ready));
        if (q16.size() != 0) begin
            chk("bit16", b16.bit_out, q16[0][1]);
            chk("last16", b16.last_bit, q16[0][0]);
        end
        chk("valid1", b1.bit_valid, q1.size() != 0);
        chk("ready1", b1.word_ready, q1.size() == 0 || (q1.size() == 1 && b1.bit_ready));
        if (q1.size() != 0) begin
            chk("bit1", b1.bit_out, q1[0][1]);
            chk("last1", b1.last_bit, q1[0][0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drain16();
        for (int k = 0; k < 60 && b16.bit_valid; k++) @(negedge clk);
        chk("drain16", b16.bit_valid, 1'b0);
    endtask

    logic [16:0] cap;
    int lc, lp, run, seen, base;

    initial begin
        b16.word_in = '0; b16.word_valid = 1'b0; b16.bit_ready = 1'b1;
        b1.word_in  = '0; b1.word_valid  = 1'b0; b1.bit_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", b16.bit_valid, 1'b0);
        chk("rst_out", b16.bit_out, 1'b0);
        chk("rst_last", b16.last_bit, 1'b0);
        chk("rst_busy", b16.busy, 1'b0);
        chk("rst_ready", b16.word_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 1/2: single word, free-running
        b16.word_in = 16'h5772; b16.word_valid = 1'b1;
        @(negedge clk);
        b16.word_valid = 1'b0;
        cap = '0; lc = 0; lp = -1;
        for (int i = 0; i < FL; i++) begin
            cap[i] = b16.bit_out;
            if (b16.last_bit) begin lc++; lp = i; end
            @(negedge clk);
        end
        chk("t1_bits", cap[15:0], 16'h5772);
        chk("t1_last_count", lc, 1);
        chk("t1_last_pos", lp, FL - 1);
        chk("t1_ready_after", b16.word_ready, 1'b1);
        chk("t1_idle_after", b16.busy, 1'b0);
`ifdef SERIALIZER_PARITY_EN
        chk("t2_parity_bit", cap[16], 1'b1 ^ PODD);
`endif

        // 3: back-to-back words, word_valid held
        base = acc16;
        b16.word_in = 16'h5772; b16.word_valid = 1'b1;
        @(negedge clk);
        b16.word_in = 16'hFFFF;
        run = 0; seen = -1;
        for (int k = 0; k < 3 * FL && b16.bit_valid; k++) begin
            if (acc16 == base + 2 && seen < 0) begin seen = run; b16.word_valid = 1'b0; end
            run++;
            @(negedge clk);
        end
        chk("t3_run_len", run, 2 * FL);
        chk("t3_second_accept", seen, FL);

        // 4: stall on bit 5
        b16.word_in = 16'h5772; b16.word_valid = 1'b1;
        @(negedge clk);
        b16.word_valid = 1'b0;
        repeat (5) @(negedge clk);
        b16.bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_bit", b16.bit_out, 1'b1);
            chk("t4_stall_last", b16.last_bit, 1'b0);
            @(negedge clk);
        end
        b16.bit_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_bit6", b16.bit_out, 1'b1);
        @(negedge clk);
        chk("t4_resume_bit7", b16.bit_out, 1'b0);
        drain16();

        // 5: asynchronous reset mid-frame at bit 7
        b16.word_in = 16'h5772; b16.word_valid = 1'b1;
        @(negedge clk);
        b16.word_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid", b16.bit_valid, 1'b0);
        chk("t5_rst_out", b16.bit_out, 1'b0);
        chk("t5_rst_busy", b16.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ready", b16.word_ready, 1'b1);
        b16.word_in = 16'h0001; b16.word_valid = 1'b1;
        @(negedge clk);
        b16.word_valid = 1'b0;
        chk("t5_first_bit", b16.bit_out, 1'b1);
        chk("t5_first_valid", b16.bit_valid, 1'b1);
        drain16();

        // 6: W=1 stream of 1,0,1
`ifndef SERIALIZER_PARITY_EN
        b1.word_in = 1'b1; b1.word_valid = 1'b1;
        @(negedge clk);
        chk("t6_bit0", b1.bit_out, 1'b1);
        chk("t6_last0", b1.last_bit, 1'b1);
        b1.word_in = 1'b0;
        @(negedge clk);
        chk("t6_bit1", b1.bit_out, 1'b0);
        chk("t6_last1", b1.last_bit, 1'b1);
        b1.word_in = 1'b1;
        @(negedge clk);
        b1.word_valid = 1'b0;
        chk("t6_bit2", b1.bit_out, 1'b1);
        chk("t6_last2", b1.last_bit, 1'b1);
        @(negedge clk);
        chk("t6_idle", b1.bit_valid, 1'b0);
        chk("t6_count", acc1, 3);
`else
        b1.word_in = 1'b1; b1.word_valid = 1'b1;
        @(negedge clk);
        b1.word_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle", b1.bit_valid, 1'b0);
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
